uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the UART TX, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd57600: stall limit in clk cycles, used only with UART_ARB_TIMEOUT_EN.
REQ-003 clk  input  1  system clock, 5.76 MHz; one clock, all logic on posedge.
REQ-004 reset_b  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i owns bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  marks the final byte of a requester's packet; qualified by req_valid.
REQ-008 req_ready  output  NUM_REQ  byte accepted when req_valid[i] and req_ready[i] are both high on a clk edge.
REQ-009 grant  output  NUM_REQ  one-hot owner of the UART; all-zero when unowned.
REQ-010 TX_Ready  input  1  UART TX controller ready (high only while that controller is idle).
REQ-011 TX_en  output  1  one-cycle start pulse to the UART TX controller.
REQ-012 TX_data  output  8  byte to the UART TX datapath; held stable from the TX_en pulse until TX_Ready returns high.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on a stall release; constant 0 without the macro.

Function
REQ-015 FSM states: IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE; all outputs are registered except req_ready.
REQ-016 IDLE: when TX_Ready=1 and any req_valid=1, grant the first valid requester searching upward from rr_ptr with wrap; go to LOAD next cycle.
REQ-017 IDLE with TX_Ready=0 issues no grant, even if requests are pending.
REQ-018 req_ready[i] = (state==LOAD) & grant[i]; never asserted for a non-granted requester.
REQ-019 LOAD: on handshake, latch the byte into TX_data and the last flag into last_q; go to SEND.
REQ-020 SEND: TX_en=1 for exactly one cycle; go to WAIT_BUSY.
REQ-021 WAIT_BUSY: stay until TX_Ready=0, then go to WAIT_DONE; TX_en=0.
REQ-022 WAIT_DONE: stay until TX_Ready=1.
REQ-023 On leaving WAIT_DONE: if last_q=1, clear grant, set rr_ptr=(owner+1) mod NUM_REQ, go to IDLE; otherwise go to LOAD with the same owner.
REQ-024 Grant is locked for the whole packet; requests from other requesters are ignored until the owner's last byte completes.
REQ-025 Latency: byte handshake at edge t -> TX_en high in cycle t+1; back-to-back bytes are separated by at least 3 cycles of arbiter overhead beyond the UART frame.
REQ-026 Single-byte packet (req_last=1 on first byte) releases grant after that one frame.
REQ-027 Changes on req_valid/req_data of non-owners, or of the owner outside LOAD, have no effect.
REQ-028 Default/illegal state: outputs go to reset values and the next state is IDLE.

Reset
REQ-029 While reset_b=0: state=IDLE, grant=0, rr_ptr=0, TX_en=0, TX_data=8'h00, busy=0, timeout_err=0, req_ready=0, stall counter=0.
REQ-030 Reset asserted mid-frame aborts the packet; after release, no new TX_en until TX_Ready=1 is observed in IDLE.

Configuration
REQ-031 Macro UART_ARB_TIMEOUT_EN defined: in LOAD, a 16-bit counter counts consecutive cycles with owner req_valid=0; on reaching TIMEOUT_CYCLES, pulse timeout_err, clear grant, advance rr_ptr past the owner, and return to IDLE; the counter clears on handshake or on leaving LOAD.
REQ-032 Macro undefined: no counter is built, LOAD waits indefinitely, and timeout_err is tied 0; the port list is unchanged.

Structure
REQ-033 Shared package uart_arb_pkg holds the state enumeration, DATA_W=8, and the default TIMEOUT_CYCLES.
REQ-034 One sub-module, uart_arb_rr_pick: combinational round-robin search (req vector and rr_ptr in, one-hot grant and valid out).

Verification
REQ-035 The bench UART model drops TX_Ready 1 cycle after TX_en and holds it low for 20 cycles.
REQ-036 Requester 1 sends 3 bytes (8'hA5, 8'h5A, 8'hFF, last on 8'hFF) -> three TX_en pulses with TX_data in that order, then grant=0 and rr_ptr=2.
REQ-037 All 4 requesters valid with single-byte packets from reset -> grants in order 0,1,2,3, each holding the bus for exactly one frame.
REQ-038 Requester 2 becomes valid mid-packet of requester 0 -> no grant change until requester 0's last byte has TX_Ready back high.
REQ-039 Reset pulsed in WAIT_BUSY while the model holds TX_Ready=0 -> all outputs reset immediately; first TX_en only after TX_Ready=1.
REQ-040 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: owner drops req_valid after byte 1 -> timeout_err pulses at stall cycle 100 and the next valid requester is granted.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and constants for the UART TX arbiter
package uart_arb_pkg;

    localparam int          DATA_W              = 8;
    localparam logic [15:0] TIMEOUT_CYCLES_DFLT = 16'd57600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// rtl/uart_arb_rr_pick.sv - combinational round-robin search starting at ptr_i with wrap
module uart_arb_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter in front of one UART TX
// Optional stall timeout in LOAD is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      TX_Ready,
    output logic                      TX_en,
    output logic [DATA_W-1:0]         TX_data,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Parameter sanity hook: an illegal configuration elaborates this empty block.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 16'd0) begin : g_illegal_cfg
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               tx_en_q, tx_en_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_vld;
    logic [PTR_W-1:0]   own_idx, next_ptr;
    logic               own_valid, own_last;
    logic [DATA_W-1:0]  own_data;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        timeout_err_q, timeout_err_d;
`endif

    uart_arb_rr_pick #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_vld)
    );

    always_comb begin
        own_idx   = '0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                own_idx   = PTR_W'(i);
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = (own_idx == PTR_W'(NUM_REQ - 1)) ? '0 : own_idx + 1'b1;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (TX_Ready && pick_vld) begin
                    grant_d = pick_gnt;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (own_valid) begin
                    tx_data_d = own_data;
                    last_d    = own_last;
                    state_d   = ST_SEND;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (stall_q == TIMEOUT_CYCLES - 16'd1) begin
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    rr_ptr_d      = next_ptr;
                    state_d       = ST_IDLE;
                end
`endif
            end
            ST_SEND: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!TX_Ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (TX_Ready) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = '0;
                rr_ptr_d  = '0;
                tx_data_d = '0;
                last_d    = 1'b0;
            end
        endcase
        // Strobes derive from the next state so they line up with it after the edge.
        tx_en_d = (state_d == ST_SEND);
        busy_d  = (state_d != ST_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
        stall_d = (state_q == ST_LOAD && !own_valid && state_d == ST_LOAD) ? stall_q + 16'd1 : 16'd0;
`endif
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            stall_q       <= stall_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_ready = (state_q == ST_LOAD) ? grant_q : '0;
    assign grant     = grant_q;
    assign TX_en     = tx_en_q;
    assign TX_data   = tx_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic        TX_Ready, TX_en, busy, timeout_err;
    logic [7:0]  TX_data;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16'd100)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .TX_Ready    (TX_Ready),
        .TX_en       (TX_en),
        .TX_data     (TX_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // UART model: ready drops one cycle after TX_en and stays low for 20 cycles.
    logic uart_rdy = 1'b1;
    int   uart_cnt = 0;
    logic hold_low = 1'b0;
    assign TX_Ready = uart_rdy && !hold_low;

    always @(posedge clk) begin
        if (uart_cnt != 0) begin
            uart_cnt <= uart_cnt - 1;
            if (uart_cnt == 1) uart_rdy <= 1'b1;
        end else if (TX_en) begin
            uart_rdy <= 1'b0;
            uart_cnt <= 20;
        end
    end

    // Per-requester byte queues: {last, data}.
    logic [8:0] fmem [4][8];
    int         wr_n [4] = '{default: 0};
    int         rd_n [4] = '{default: 0};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i]) rd_n[i] <= rd_n[i] + 1;
    end

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = rd_n[i] < wr_n[i];
            req_last[i]         = fmem[i][rd_n[i] & 7][8];
            req_data[i*8 +: 8]  = fmem[i][rd_n[i] & 7][7:0];
        end
    end

    // Monitor: log each TX_en and check TX_en follows exactly one cycle after a handshake.
    logic [7:0] log_data  [16];
    logic [3:0] log_grant [16];
    int   log_n   = 0;
    int   lat_err = 0;
    int   rdy_err = 0;
    int   to_n    = 0;
    logic hs_prev = 1'b0;

    always @(negedge clk) begin
        if (TX_en && log_n < 16) begin
            log_data[log_n]  = TX_data;
            log_grant[log_n] = grant;
            log_n++;
        end
        if (TX_en !== hs_prev) lat_err++;
        hs_prev = |(req_valid & req_ready);
        if ((req_ready & ~grant) != 4'b0) rdy_err++;
        if (timeout_err) to_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int r, input logic last, input logic [7:0] d);
        fmem[r][wr_n[r] & 7] = {last, d};
        wr_n[r]++;
    endtask

    task automatic wait_done(input int n_exp, input string tag);
        int c = 0;
        while (!(log_n >= n_exp && grant == 4'b0 && !busy) && c < 3000) begin
            tick();
            c++;
        end
        check(tag, 32'(c < 3000), 32'd1);
    endtask

    initial begin
        int c;
        reset_b = 1'b0;
        repeat (3) tick();
        check("rst_grant",   32'(grant),        32'h0);
        check("rst_txen",    32'(TX_en),        32'h0);
        check("rst_txdata",  32'(TX_data),      32'h00);
        check("rst_busy",    32'(busy),         32'h0);
        check("rst_toerr",   32'(timeout_err),  32'h0);
        check("rst_ready",   32'(req_ready),    32'h0);
        check("rst_rrptr",   32'(dut.rr_ptr_q), 32'h0);
        reset_b = 1'b1;
        tick();

        // Three-byte packet from requester 1.
        log_n = 0;
        push(1, 1'b0, 8'hA5);
        push(1, 1'b0, 8'h5A);
        push(1, 1'b1, 8'hFF);
        wait_done(3, "a_done");
        check("a_count",  32'(log_n),        32'd3);
        check("a_d0",     32'(log_data[0]),  32'hA5);
        check("a_d1",     32'(log_data[1]),  32'h5A);
        check("a_d2",     32'(log_data[2]),  32'hFF);
        check("a_g0",     32'(log_grant[0]), 32'h2);
        check("a_g1",     32'(log_grant[1]), 32'h2);
        check("a_g2",     32'(log_grant[2]), 32'h2);
        check("a_grant",  32'(grant),        32'h0);
        check("a_rrptr",  32'(dut.rr_ptr_q), 32'h2);

        // All four requesters with single-byte packets from reset.
        reset_b = 1'b0;
        tick();
        tick();
        reset_b = 1'b1;
        tick();
        log_n = 0;
        for (int r = 0; r < 4; r++) push(r, 1'b1, 8'h10 + 8'(r));
        wait_done(4, "b_done");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b_d%0d", k), 32'(log_data[k]),  32'h10 + k);
            check($sformatf("b_g%0d", k), 32'(log_grant[k]), 32'h1 << k);
        end

        // Requester 2 arrives mid-packet of requester 0.
        log_n = 0;
        push(0, 1'b0, 8'h20);
        push(0, 1'b0, 8'h21);
        push(0, 1'b1, 8'h22);
        c = 0;
        while (log_n < 1 && c < 500) begin tick(); c++; end
        push(2, 1'b1, 8'h30);
        wait_done(4, "c_done");
        check("c_d0", 32'(log_data[0]),  32'h20);
        check("c_d1", 32'(log_data[1]),  32'h21);
        check("c_d2", 32'(log_data[2]),  32'h22);
        check("c_d3", 32'(log_data[3]),  32'h30);
        check("c_g2", 32'(log_grant[2]), 32'h1);
        check("c_g3", 32'(log_grant[3]), 32'h4);

        // Reset while in WAIT_BUSY with the UART holding ready low.
        log_n = 0;
        push(3, 1'b1, 8'h40);
        c = 0;
        while (log_n < 1 && c < 500) begin tick(); c++; end
        check("d_first_txen", 32'(c < 500), 32'd1);
        tick();
        reset_b  = 1'b0;
        hold_low = 1'b1;
        #1;
        check("d_rst_grant",  32'(grant),     32'h0);
        check("d_rst_busy",   32'(busy),      32'h0);
        check("d_rst_txdata", 32'(TX_data),   32'h00);
        check("d_rst_txen",   32'(TX_en),     32'h0);
        check("d_rst_ready",  32'(req_ready), 32'h0);
        push(1, 1'b1, 8'h50);
        repeat (3) tick();
        reset_b = 1'b1;
        log_n = 0;
        repeat (30) tick();
        check("d_hold_txen",  32'(log_n), 32'd0);
        check("d_hold_grant", 32'(grant), 32'h0);
        check("d_hold_busy",  32'(busy),  32'h0);
        hold_low = 1'b0;
        wait_done(1, "d_done");
        check("d_d0", 32'(log_data[0]),  32'h50);
        check("d_g0", 32'(log_grant[0]), 32'h2);

`ifdef UART_ARB_TIMEOUT_EN
        // Owner 2 stalls after its first byte; requester 3 takes over after the timeout.
        log_n = 0;
        push(2, 1'b0, 8'h60);
        push(3, 1'b1, 8'h70);
        wait_done(2, "t_done");
        check("t_d0", 32'(log_data[0]),  32'h60);
        check("t_g0", 32'(log_grant[0]), 32'h4);
        check("t_d1", 32'(log_data[1]),  32'h70);
        check("t_g1", 32'(log_grant[1]), 32'h8);
        check("t_pulses", 32'(to_n), 32'd1);
`else
        check("t_pulses", 32'(to_n), 32'd0);
`endif

        check("latency_txen",  32'(lat_err), 32'd0);
        check("ready_nongrnt", 32'(rdy_err), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
